// File: rtl/trng_ehr_collector.sv
// Packs the decimated TRNG bit stream into the entropy holding register and
// runs a continuous repeated-word test on every completed word before handing the EHR to the PRNG.
module trng_ehr_collector #(
  parameter int EHR_WIDTH     = 192,
  parameter int WORD_WIDTH    = 32,
  parameter int ERR_CNT_WIDTH = 8
) (
  input  logic                           rng_clk,
  input  logic                           rst_n,
  input  logic                           rnd_src_enable,
  input  logic                           rnd_bit,
  input  logic                           rnd_bit_valid,
  input  logic                           crngt_bypass,
  input  logic                           prng_trng_ehr_rd,
  output logic [EHR_WIDTH-1:0]           trng_prng_ehr_data,
  output logic                           trng_prng_ehr_valid,
  output logic                           crngt_err_1p,
  output logic [ERR_CNT_WIDTH-1:0]       crngt_err_cnt,
  output logic [$clog2(EHR_WIDTH+1)-1:0] bits_cntr
);

  localparam int CNT_W = $clog2(EHR_WIDTH + 1);
  localparam logic [CNT_W-1:0] WORD_W_C = CNT_W'(WORD_WIDTH);
  localparam logic [CNT_W-1:0] EHR_W_C  = CNT_W'(EHR_WIDTH);

  typedef enum logic [1:0] {IDLE, COLLECT, FULL} state_t;

  state_t                   state_q, state_d;
  logic [EHR_WIDTH-1:0]     ehr_q, ehr_d;
  logic [CNT_W-1:0]         bits_q, bits_d;
  logic                     err_1p_q, err_1p_d;
  logic [ERR_CNT_WIDTH-1:0] err_cnt_q, err_cnt_d;
  logic [WORD_WIDTH-1:0]    prev_word_q, prev_word_d;
  logic                     prev_valid_q, prev_valid_d;

  logic [CNT_W-1:0]         bits_inc;
  logic [CNT_W-1:0]         word_base;
  logic                     word_done;
  logic [WORD_WIDTH-1:0]    new_word;

  // The accepted bit completes a word when the incremented count lands on a word boundary.
  assign bits_inc  = bits_q + CNT_W'(1);
  assign word_done = ((bits_inc % WORD_W_C) == '0);
  assign word_base = (bits_q / WORD_W_C) * WORD_W_C;

  always_ff @(posedge rng_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      ehr_q        <= '0;
      bits_q       <= '0;
      err_1p_q     <= 1'b0;
      err_cnt_q    <= '0;
      prev_word_q  <= '0;
      prev_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      ehr_q        <= ehr_d;
      bits_q       <= bits_d;
      err_1p_q     <= err_1p_d;
      err_cnt_q    <= err_cnt_d;
      prev_word_q  <= prev_word_d;
      prev_valid_q <= prev_valid_d;
    end
  end

  // Disabling the source wins over everything else; the failure count survives it.
  always_comb begin
    state_d      = state_q;
    ehr_d        = ehr_q;
    bits_d       = bits_q;
    err_1p_d     = 1'b0;
    err_cnt_d    = err_cnt_q;
    prev_word_d  = prev_word_q;
    prev_valid_d = prev_valid_q;
    new_word     = '0;

    if (!rnd_src_enable) begin
      state_d      = IDLE;
      ehr_d        = '0;
      bits_d       = '0;
      prev_word_d  = '0;
      prev_valid_d = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: state_d = COLLECT;

        COLLECT: begin
          if (rnd_bit_valid) begin
            ehr_d[bits_q] = rnd_bit;
            bits_d        = bits_inc;
            if (word_done) begin
              new_word = ehr_d[word_base +: WORD_WIDTH];
              if (prev_valid_q && !crngt_bypass && (new_word == prev_word_q)) begin
                // A stuck source is rejected: discard the whole fill and start over.
                err_1p_d = 1'b1;
                if (err_cnt_q != '1) err_cnt_d = err_cnt_q + ERR_CNT_WIDTH'(1);
                ehr_d  = '0;
                bits_d = '0;
              end else begin
                prev_word_d  = new_word;
                prev_valid_d = 1'b1;
                if (bits_inc == EHR_W_C) state_d = FULL;
              end
            end
          end
        end

        FULL: begin
          if (prng_trng_ehr_rd) begin
            state_d = COLLECT;
            ehr_d   = '0;
            bits_d  = '0;
          end
        end

        default: state_d = IDLE;
      endcase
    end
  end

  assign trng_prng_ehr_data  = ehr_q;
  assign trng_prng_ehr_valid = (state_q == FULL);
  assign crngt_err_1p        = err_1p_q;
  assign crngt_err_cnt       = err_cnt_q;
  assign bits_cntr           = bits_q;

endmodule

// File: tb/tb_trng_ehr_collector.sv
// Scoreboard bench for trng_ehr_collector: a word-level model predicts EHR deliveries
// and CRNGT failures, and a monitor compares them whenever the DUT presents them.
module tb_trng_ehr_collector;

  localparam int EHR_WIDTH     = 192;
  localparam int WORD_WIDTH    = 32;
  localparam int ERR_CNT_WIDTH = 8;
  localparam int CNT_W         = $clog2(EHR_WIDTH + 1);
  localparam int N_WORDS       = EHR_WIDTH / WORD_WIDTH;
  localparam int ERR_MAX       = (1 << ERR_CNT_WIDTH) - 1;

  typedef logic [EHR_WIDTH-1:0] wide_t;

  logic rng_clk          = 1'b0;
  logic rst_n            = 1'b1;
  logic rnd_src_enable   = 1'b0;
  logic rnd_bit          = 1'b0;
  logic rnd_bit_valid    = 1'b0;
  logic crngt_bypass     = 1'b0;
  logic prng_trng_ehr_rd = 1'b0;

  wire [EHR_WIDTH-1:0]     trng_prng_ehr_data;
  wire                     trng_prng_ehr_valid;
  wire                     crngt_err_1p;
  wire [ERR_CNT_WIDTH-1:0] crngt_err_cnt;
  wire [CNT_W-1:0]         bits_cntr;

  trng_ehr_collector #(
    .EHR_WIDTH(EHR_WIDTH), .WORD_WIDTH(WORD_WIDTH), .ERR_CNT_WIDTH(ERR_CNT_WIDTH)
  ) dut (
    .rng_clk(rng_clk),
    .rst_n(rst_n),
    .rnd_src_enable(rnd_src_enable),
    .rnd_bit(rnd_bit),
    .rnd_bit_valid(rnd_bit_valid),
    .crngt_bypass(crngt_bypass),
    .prng_trng_ehr_rd(prng_trng_ehr_rd),
    .trng_prng_ehr_data(trng_prng_ehr_data),
    .trng_prng_ehr_valid(trng_prng_ehr_valid),
    .crngt_err_1p(crngt_err_1p),
    .crngt_err_cnt(crngt_err_cnt),
    .bits_cntr(bits_cntr)
  );

  always #5 rng_clk = ~rng_clk;

  int n_checks = 0;
  int n_fail   = 0;

  wide_t                   ehr_q[$];
  logic [ERR_CNT_WIDTH-1:0] err_q[$];

  // Reference model state, tracked per completed word
  wide_t           m_data;
  int              m_words;
  logic [WORD_WIDTH-1:0] m_prev;
  bit              m_prev_valid;
  bit              m_full;
  int              m_err;

  task automatic checkOutput(input string name, input wide_t act, input wide_t exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic modelClear(input bit drop_prev);
    m_data  = '0;
    m_words = 0;
    m_full  = 1'b0;
    if (drop_prev) begin
      m_prev       = '0;
      m_prev_valid = 1'b0;
    end
  endtask

  task automatic modelWord(input logic [WORD_WIDTH-1:0] w);
    if (m_full) return;
    if (m_prev_valid && !crngt_bypass && (w == m_prev)) begin
      if (m_err < ERR_MAX) m_err++;
      err_q.push_back(ERR_CNT_WIDTH'(m_err));
      m_data  = '0;
      m_words = 0;
    end else begin
      m_prev       = w;
      m_prev_valid = 1'b1;
      m_data[m_words*WORD_WIDTH +: WORD_WIDTH] = w;
      m_words++;
      if (m_words == N_WORDS) begin
        m_full = 1'b1;
        ehr_q.push_back(m_data);
      end
    end
  endtask

  // Sends nbits of w LSB first with random idle gaps; only whole words reach the model.
  task automatic applyStimulus(input logic [WORD_WIDTH-1:0] w, input int nbits);
    for (int j = 0; j < nbits; j++) begin
      repeat ($urandom_range(0, 2)) begin
        rnd_bit_valid = 1'b0;
        rnd_bit       = 1'($urandom);
        @(posedge rng_clk); #1;
      end
      rnd_bit_valid = 1'b1;
      rnd_bit       = w[j];
      @(posedge rng_clk); #1;
      rnd_bit_valid = 1'b0;
    end
    if (nbits == WORD_WIDTH) modelWord(w);
  endtask

  task automatic enableSrc();
    rnd_src_enable = 1'b1;
    rnd_bit_valid  = 1'b0;
    @(posedge rng_clk); #1;
  endtask

  task automatic waitValid();
    int c = 0;
    while (!trng_prng_ehr_valid && c < 200) begin
      @(posedge rng_clk); #1;
      c++;
    end
    if (!trng_prng_ehr_valid) begin
      n_checks++;
      n_fail++;
      $display("[TB] FAIL wait_valid_timeout: valid still 0 after %0d cycles, required 1", c);
    end
  endtask

  task automatic readEhr(input string tag);
    prng_trng_ehr_rd = 1'b1;
    @(posedge rng_clk); #1;
    prng_trng_ehr_rd = 1'b0;
    checkOutput({tag, "_valid_after_rd"}, wide_t'(trng_prng_ehr_valid), wide_t'(0));
    checkOutput({tag, "_data_after_rd"}, trng_prng_ehr_data, wide_t'(0));
    checkOutput({tag, "_bits_after_rd"}, wide_t'(bits_cntr), wide_t'(0));
    modelClear(1'b0);
  endtask

  // Monitor: pops an expectation every time the DUT flags a failure or a newly full EHR.
  initial begin
    logic v_prev;
    logic [ERR_CNT_WIDTH-1:0] e;
    wide_t d;
    v_prev = 1'b0;
    forever begin
      @(negedge rng_clk);
      if (rst_n) begin
        if (crngt_err_1p) begin
          if (err_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("[TB] FAIL unexpected_err_pulse: got pulse with cnt=%0d, required none", crngt_err_cnt);
          end else begin
            e = err_q.pop_front();
            checkOutput("err_cnt_at_pulse", wide_t'(crngt_err_cnt), wide_t'(e));
            checkOutput("bits_at_pulse", wide_t'(bits_cntr), wide_t'(0));
            checkOutput("data_at_pulse", trng_prng_ehr_data, wide_t'(0));
          end
        end
        if (trng_prng_ehr_valid && !v_prev) begin
          if (ehr_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("[TB] FAIL unexpected_valid: got data 0x%0h, required no delivery", trng_prng_ehr_data);
          end else begin
            d = ehr_q.pop_front();
            checkOutput("ehr_data", trng_prng_ehr_data, d);
            checkOutput("ehr_bits_full", wide_t'(bits_cntr), wide_t'(EHR_WIDTH));
          end
        end
        v_prev = trng_prng_ehr_valid;
      end else begin
        v_prev = 1'b0;
      end
    end
  end

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [WORD_WIDTH-1:0] w, last;
    wide_t held;
    int g;

    m_err = 0;
    modelClear(1'b1);

    #2 rst_n = 1'b0;
    #10;
    checkOutput("rst_data", trng_prng_ehr_data, wide_t'(0));
    checkOutput("rst_valid", wide_t'(trng_prng_ehr_valid), wide_t'(0));
    checkOutput("rst_err_1p", wide_t'(crngt_err_1p), wide_t'(0));
    checkOutput("rst_err_cnt", wide_t'(crngt_err_cnt), wide_t'(0));
    checkOutput("rst_bits", wide_t'(bits_cntr), wide_t'(0));
    @(posedge rng_clk); #1;
    rst_n = 1'b1;
    @(posedge rng_clk); #1;

    $display("[TB] basic fill of words 1..6");
    enableSrc();
    for (int k = 1; k <= N_WORDS; k++) applyStimulus(WORD_WIDTH'(k), WORD_WIDTH);
    waitValid();
    checkOutput("fill1_err_cnt", wide_t'(crngt_err_cnt), wide_t'(0));
    held = trng_prng_ehr_data;

    $display("[TB] extra bits while full, then read");
    applyStimulus(WORD_WIDTH'($urandom), WORD_WIDTH);
    applyStimulus(WORD_WIDTH'($urandom), 18);
    checkOutput("data_held_in_full", trng_prng_ehr_data, held);
    checkOutput("bits_held_in_full", wide_t'(bits_cntr), wide_t'(EHR_WIDTH));
    readEhr("fill1");

    $display("[TB] repeated words across and within fills");
    applyStimulus(32'h6, WORD_WIDTH);
    applyStimulus(32'h11, WORD_WIDTH);
    applyStimulus(32'h22, WORD_WIDTH);
    applyStimulus(32'h22, WORD_WIDTH);
    checkOutput("err_cnt_after_repeat", wide_t'(crngt_err_cnt), wide_t'(m_err));
    for (int k = 0; k < N_WORDS; k++) applyStimulus(WORD_WIDTH'(32'h33 + k * 32'h11), WORD_WIDTH);
    waitValid();
    readEhr("fill2");

    $display("[TB] bypass with repeated words");
    crngt_bypass = 1'b1;
    applyStimulus(32'hAA, WORD_WIDTH);
    applyStimulus(32'hBB, WORD_WIDTH);
    applyStimulus(32'hBB, WORD_WIDTH);
    applyStimulus(32'hBB, WORD_WIDTH);
    applyStimulus(32'hCC, WORD_WIDTH);
    applyStimulus(32'hCC, WORD_WIDTH);
    waitValid();
    checkOutput("bypass_err_cnt", wide_t'(crngt_err_cnt), wide_t'(m_err));
    readEhr("bypass");
    crngt_bypass = 1'b0;

    $display("[TB] random fills with occasional repeats");
    last = m_prev;
    for (int f = 0; f < 3; f++) begin
      g = 0;
      while (!m_full && g < 200) begin
        w = ($urandom_range(0, 7) == 0) ? last : WORD_WIDTH'($urandom);
        applyStimulus(w, WORD_WIDTH);
        last = w;
        g++;
      end
      if (m_full) begin
        waitValid();
        readEhr("rand");
      end
    end

    $display("[TB] read outside full, then disable mid-fill");
    applyStimulus(32'h5, WORD_WIDTH);
    applyStimulus(32'h6, WORD_WIDTH);
    prng_trng_ehr_rd = 1'b1;
    @(posedge rng_clk); #1;
    prng_trng_ehr_rd = 1'b0;
    checkOutput("rd_ignored_bits", wide_t'(bits_cntr), wide_t'(m_words * WORD_WIDTH));
    applyStimulus(WORD_WIDTH'($urandom), 6);
    checkOutput("partial_bits", wide_t'(bits_cntr), wide_t'(m_words * WORD_WIDTH + 6));
    rnd_src_enable = 1'b0;
    rnd_bit_valid  = 1'b1;
    rnd_bit        = 1'b1;
    @(posedge rng_clk); #1;
    rnd_bit_valid = 1'b0;
    modelClear(1'b1);
    checkOutput("disable_bits", wide_t'(bits_cntr), wide_t'(0));
    checkOutput("disable_data", trng_prng_ehr_data, wide_t'(0));
    checkOutput("disable_valid", wide_t'(trng_prng_ehr_valid), wide_t'(0));
    checkOutput("disable_err_cnt_kept", wide_t'(crngt_err_cnt), wide_t'(m_err));
    enableSrc();
    for (int k = 6; k < 6 + N_WORDS; k++) applyStimulus(WORD_WIDTH'(k), WORD_WIDTH);
    waitValid();
    readEhr("reenable");

    $display("[TB] saturate failure counter");
    applyStimulus(32'hDEAD0000, WORD_WIDTH);
    repeat (260) applyStimulus(32'hDEAD0000, WORD_WIDTH);
    @(posedge rng_clk); #1;
    checkOutput("err_cnt_saturated", wide_t'(crngt_err_cnt), wide_t'(ERR_MAX));

    $display("[TB] asynchronous reset mid-fill");
    applyStimulus(32'h12345678, WORD_WIDTH);
    applyStimulus(32'h9ABCDEF0, 8);
    rst_n = 1'b0;
    #1;
    checkOutput("midrst_data", trng_prng_ehr_data, wide_t'(0));
    checkOutput("midrst_valid", wide_t'(trng_prng_ehr_valid), wide_t'(0));
    checkOutput("midrst_err_1p", wide_t'(crngt_err_1p), wide_t'(0));
    checkOutput("midrst_err_cnt", wide_t'(crngt_err_cnt), wide_t'(0));
    checkOutput("midrst_bits", wide_t'(bits_cntr), wide_t'(0));

    checkOutput("ehr_queue_drained", wide_t'(ehr_q.size()), wide_t'(0));
    checkOutput("err_queue_drained", wide_t'(err_q.size()), wide_t'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
